shift_reg_pio: RTL and testbench

Parametrised universal shift register: the successor to the single-bit, two-direction shift register. Adds multi-bit steps (LANES bits per step), parallel load, logical, rotate and arithmetic modes, and a self-timed burst engine that runs N steps with busy/done handshake. Used wherever a datapath needs serialisation, deserialisation or barrel-style stepping without an external counter.

---
 rtl/shift_reg_pio_if.sv | 50 +++++
 rtl/shift_reg_pio.sv | 106 ++++++++++
 tb/tb_shift_reg_pio.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_pio_if.sv
// Handshake and data bundle for the universal shift register.
// master drives controls; slave is the register itself.
interface shift_reg_pio_if #(
    parameter int WIDTH = 10,
    parameter int LANES = 1,
    parameter int CNT_W = $clog2(WIDTH / LANES + 1)
);
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [2:0]       mode;
    logic             shift_en;
    logic [LANES-1:0] ser_in;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] data_out;
    logic [LANES-1:0] ser_out_lsb;
    logic [LANES-1:0] ser_out_msb;
    logic             busy;
    logic             done;

    modport master (
        output load,
        output load_data,
        output mode,
        output shift_en,
        output ser_in,
        output burst_start,
        output burst_len,
        input  data_out,
        input  ser_out_lsb,
        input  ser_out_msb,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  load_data,
        input  mode,
        input  shift_en,
        input  ser_in,
        input  burst_start,
        input  burst_len,
        output data_out,
        output ser_out_lsb,
        output ser_out_msb,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_reg_pio.sv
// Universal multi-lane shift register with parallel load,
// logical/rotate/arithmetic steps and a self-timed burst engine.
module shift_reg_pio #(
    parameter int WIDTH = 10,
    parameter int LANES = 1
) (
    input  logic            clk,
    input  logic            rst,
    shift_reg_pio_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH / LANES + 1);

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_SHL  = 3'd1;
    localparam logic [2:0] M_SHR  = 3'd2;
    localparam logic [2:0] M_ROL  = 3'd3;
    localparam logic [2:0] M_ROR  = 3'd4;
    localparam logic [2:0] M_ASR  = 3'd5;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bmode_q;
    logic [2:0]       op_mode;
    logic             busy_q;
    logic             done_q;

    // One step of the selected operation; reserved codes hold.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] d,
        input logic [LANES-1:0] fill
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            M_SHL:   r = {d[WIDTH-LANES-1:0], fill};
            M_SHR:   r = {fill, d[WIDTH-1:LANES]};
            M_ROL:   r = {d[WIDTH-LANES-1:0], d[WIDTH-1:WIDTH-LANES]};
            M_ROR:   r = {d[LANES-1:0], d[WIDTH-1:LANES]};
            M_ASR:   r = {{LANES{d[WIDTH-1]}}, d[WIDTH-1:LANES]};
            M_HOLD:  r = d;
            default: r = d;
        endcase
        return r;
    endfunction

    // A running burst uses its captured mode; otherwise the live mode.
    always_comb begin
        op_mode = bus.mode;
        if (state_q == RUN) begin
            op_mode = bmode_q;
        end
        step_d = step_fn(op_mode, data_q, bus.ser_in);
    end

    // Register, burst FSM and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            bmode_q <= M_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                // Load aborts any burst silently.
                data_q  <= bus.load_data;
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else if (state_q == RUN) begin
                data_q <= step_d;
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else if (bus.burst_start && (bus.burst_len != '0)) begin
                // Capture only; the first step is on the next edge.
                bmode_q <= bus.mode;
                cnt_q   <= bus.burst_len;
                state_q <= RUN;
                busy_q  <= 1'b1;
            end else if (bus.shift_en) begin
                data_q <= step_d;
            end
        end
    end

    assign bus.data_out    = data_q;
    assign bus.ser_out_lsb = data_q[LANES-1:0];
    assign bus.ser_out_msb = data_q[WIDTH-1:WIDTH-LANES];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_shift_reg_pio.sv
// Directed self-checking bench for shift_reg_pio.
// Two instances: 8x1-lane and 8x2-lane.
module tb_shift_reg_pio;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    shift_reg_pio_if #(.WIDTH(8), .LANES(1)) b1 ();
    shift_reg_pio_if #(.WIDTH(8), .LANES(2)) b2 ();

    shift_reg_pio #(.WIDTH(8), .LANES(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    shift_reg_pio #(.WIDTH(8), .LANES(2)) u2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        b1.load = 0; b1.load_data = '0; b1.mode = 0;
        b1.shift_en = 0; b1.ser_in = '0;
        b1.burst_start = 0; b1.burst_len = '0;
        b2.load = 0; b2.load_data = '0; b2.mode = 0;
        b2.shift_en = 0; b2.ser_in = '0;
        b2.burst_start = 0; b2.burst_len = '0;
    endtask

    task automatic test_reset;
        rst = 1;
        tick();
        rst = 0;
        total_cnt++;
        if (b1.data_out !== 8'h00) $display("FAIL reset_data1 got %h exp 00", b1.data_out);
        else pass_cnt++;
        total_cnt++;
        if (b1.busy !== 1'b0 || b1.done !== 1'b0)
            $display("FAIL reset_flags1 got busy=%b done=%b exp 0 0", b1.busy, b1.done);
        else pass_cnt++;
        total_cnt++;
        if (b2.data_out !== 8'h00 || b2.ser_out_lsb !== 2'b00 || b2.ser_out_msb !== 2'b00)
            $display("FAIL reset_data2 got %h exp 00", b2.data_out);
        else pass_cnt++;
    endtask

    task automatic test_shl;
        b1.load = 1; b1.load_data = 8'hA5;
        tick();
        b1.load = 0;
        b1.mode = 3'd1; b1.ser_in = 1'b1; b1.shift_en = 1;
        tick();
        b1.shift_en = 0;
        total_cnt++;
        if (b1.data_out !== 8'h4B) $display("FAIL shl_data got %h exp 4b", b1.data_out);
        else pass_cnt++;
        total_cnt++;
        if (b1.ser_out_msb !== 1'b0 || b1.ser_out_lsb !== 1'b1)
            $display("FAIL shl_serout got msb=%b lsb=%b exp 0 1", b1.ser_out_msb, b1.ser_out_lsb);
        else pass_cnt++;
    endtask

    task automatic test_asr_rol;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'hC0; exp_v[1] = 8'hE0; exp_v[2] = 8'hF0;
        b1.load = 1; b1.load_data = 8'h80;
        tick();
        b1.load = 0;
        b1.mode = 3'd5; b1.ser_in = 1'b0; b1.shift_en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (b1.data_out !== exp_v[i])
                $display("FAIL asr_step%0d got %h exp %h", i, b1.data_out, exp_v[i]);
            else pass_cnt++;
        end
        b1.shift_en = 0;
        b1.load = 1; b1.load_data = 8'h81;
        tick();
        b1.load = 0;
        b1.mode = 3'd3; b1.shift_en = 1;
        tick();
        b1.shift_en = 0;
        total_cnt++;
        if (b1.data_out !== 8'h03) $display("FAIL rol_data got %h exp 03", b1.data_out);
        else pass_cnt++;
    endtask

    task automatic test_burst_ror;
        b1.load = 1; b1.load_data = 8'hF0;
        tick();
        b1.load = 0;
        b1.mode = 3'd4; b1.ser_in = 1'b1;
        b1.burst_start = 1; b1.burst_len = 4'd4;
        tick();
        b1.burst_start = 0; b1.burst_len = '0;
        b1.mode = 3'd1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (b1.busy !== 1'b1 || b1.done !== 1'b0)
                $display("FAIL burst_busy%0d got busy=%b done=%b exp 1 0", i, b1.busy, b1.done);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (b1.busy !== 1'b0 || b1.done !== 1'b1)
            $display("FAIL burst_end got busy=%b done=%b exp 0 1", b1.busy, b1.done);
        else pass_cnt++;
        total_cnt++;
        if (b1.data_out !== 8'h0F) $display("FAIL burst_data got %h exp 0f", b1.data_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b1.done !== 1'b0 || b1.data_out !== 8'h0F)
            $display("FAIL burst_done_pulse got done=%b data=%h exp 0 0f", b1.done, b1.data_out);
        else pass_cnt++;
    endtask

    task automatic test_lanes2;
        b2.load = 1; b2.load_data = 8'h00;
        tick();
        b2.load = 0;
        b2.mode = 3'd2; b2.ser_in = 2'b11; b2.shift_en = 1;
        tick();
        total_cnt++;
        if (b2.data_out !== 8'hC0) $display("FAIL shr2_step0 got %h exp c0", b2.data_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b2.data_out !== 8'hF0) $display("FAIL shr2_step1 got %h exp f0", b2.data_out);
        else pass_cnt++;
        b2.mode = 3'd7;
        tick();
        b2.shift_en = 0;
        total_cnt++;
        if (b2.data_out !== 8'hF0) $display("FAIL reserved_hold got %h exp f0", b2.data_out);
        else pass_cnt++;
        // 5 ROL-by-2 steps on 8 bits wraps to a net rotate of 2.
        b2.load = 1; b2.load_data = 8'h1B;
        tick();
        b2.load = 0;
        b2.mode = 3'd3; b2.burst_start = 1; b2.burst_len = 3'd5;
        tick();
        b2.burst_start = 0; b2.burst_len = '0;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++;
        if (b2.data_out !== 8'h6C || b2.done !== 1'b1)
            $display("FAIL rol_wrap got data=%h done=%b exp 6c 1", b2.data_out, b2.done);
        else pass_cnt++;
    endtask

    task automatic test_abort_reset;
        b1.load = 1; b1.load_data = 8'h00;
        tick();
        b1.load = 0;
        b1.mode = 3'd1; b1.ser_in = 1'b1;
        b1.burst_start = 1; b1.burst_len = 4'd6;
        tick();
        b1.burst_start = 0; b1.burst_len = '0;
        tick();
        tick();
        total_cnt++;
        if (b1.data_out !== 8'h03 || b1.busy !== 1'b1)
            $display("FAIL abort_pre got data=%h busy=%b exp 03 1", b1.data_out, b1.busy);
        else pass_cnt++;
        b1.load = 1; b1.load_data = 8'h3C;
        tick();
        b1.load = 0;
        total_cnt++;
        if (b1.data_out !== 8'h3C || b1.busy !== 1'b0 || b1.done !== 1'b0)
            $display("FAIL abort_load got data=%h busy=%b done=%b exp 3c 0 0",
                     b1.data_out, b1.busy, b1.done);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (b1.data_out !== 8'h3C || b1.done !== 1'b0 || b1.busy !== 1'b0)
            $display("FAIL abort_after got data=%h done=%b exp 3c 0", b1.data_out, b1.done);
        else pass_cnt++;
        b1.burst_start = 1; b1.burst_len = 4'd6;
        tick();
        b1.burst_start = 0; b1.burst_len = '0;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        total_cnt++;
        if (b1.data_out !== 8'h00 || b1.busy !== 1'b0 || b1.done !== 1'b0)
            $display("FAIL abort_rst got data=%h busy=%b done=%b exp 00 0 0",
                     b1.data_out, b1.busy, b1.done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b1.done !== 1'b0 || b1.busy !== 1'b0)
            $display("FAIL abort_rst_after got done=%b busy=%b exp 0 0", b1.done, b1.busy);
        else pass_cnt++;
    endtask

    task automatic test_edges;
        b1.mode = 3'd1; b1.ser_in = 1'b1;
        b1.burst_start = 1; b1.burst_len = 4'd0;
        tick();
        b1.burst_start = 0;
        total_cnt++;
        if (b1.busy !== 1'b0 || b1.data_out !== 8'h00)
            $display("FAIL len0_busy got busy=%b data=%h exp 0 00", b1.busy, b1.data_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (b1.done !== 1'b0) $display("FAIL len0_done got %b exp 0", b1.done);
        else pass_cnt++;
        b1.load = 1; b1.load_data = 8'h01;
        tick();
        b1.load = 0;
        b1.mode = 3'd3; b1.burst_start = 1; b1.burst_len = 4'd2;
        tick();
        b1.mode = 3'd4; b1.burst_len = 4'd5;
        tick();
        b1.burst_start = 0; b1.burst_len = '0;
        tick();
        total_cnt++;
        if (b1.data_out !== 8'h04 || b1.busy !== 1'b0 || b1.done !== 1'b1)
            $display("FAIL start_while_busy got data=%h busy=%b done=%b exp 04 0 1",
                     b1.data_out, b1.busy, b1.done);
        else pass_cnt++;
        b1.mode = 3'd1; b1.ser_in = 1'b1;
        b1.load = 1; b1.load_data = 8'h55; b1.shift_en = 1;
        tick();
        b1.load = 0; b1.shift_en = 0;
        total_cnt++;
        if (b1.data_out !== 8'h55) $display("FAIL load_vs_shift got %h exp 55", b1.data_out);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_shl();
        test_asr_rol();
        test_burst_ror();
        test_lanes2();
        test_abort_reset();
        test_edges();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
